// File: rtl/cache_block_pkg.sv
// cache_block_pkg: shared cache geometry defaults and access encodings
`define CACHE_DEBUG_ERROR(msg) $error("cache: %s", msg)
package cache_block_pkg;
  localparam int LINE_WIDTH = 128;
  localparam int LINE_ADDR_START_INDEX = 4;
  localparam int NUM_LINES = 4;
  localparam int INSTRUCTION_LENGTH = 32;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  localparam logic NONE = 1'b0;
  localparam logic ALWAYS_TRUE = 1'b1;
endpackage

// File: rtl/cache_block_line_store.sv
// cache_block_line_store: valid/dirty/tag/data arrays with word-write and line-fill ports
module cache_block_line_store
  import cache_block_pkg::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int NUM_LINES = 4,
  parameter int IW = 2,
  parameter int TW = 26,
  parameter int WW = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IW-1:0]                 index,
  input  logic [WW-1:0]                 word,
  input  logic [INSTRUCTION_LENGTH-1:0] word_data,
  input  logic                          word_write,
  input  logic                          fill,
  input  logic [TW-1:0]                 fill_tag,
  input  logic [LINE_WIDTH-1:0]         fill_data,
  input  logic                          clear_dirty,
  output logic                          line_valid,
  output logic                          line_dirty,
  output logic [TW-1:0]                 line_tag,
  output logic [LINE_WIDTH-1:0]         line_data
);
  logic [NUM_LINES-1:0] valid_bits, dirty_bits;
  logic [TW-1:0] tags [NUM_LINES];
  logic [LINE_WIDTH-1:0] lines [NUM_LINES];
  assign line_valid = valid_bits[index];
  assign line_dirty = dirty_bits[index];
  assign line_tag = tags[index];
  assign line_data = lines[index];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= 1'b0;
    end else if (word_write) dirty_bits[index] <= 1'b1;
    else if (clear_dirty) dirty_bits[index] <= 1'b0;
  // tag/data need no reset: they are only observed through a set valid bit
  always_ff @(posedge clock)
    if (fill) begin
      tags[index] <= fill_tag;
      lines[index] <= fill_data;
    end else if (word_write) lines[index][int'(word)*INSTRUCTION_LENGTH +: INSTRUCTION_LENGTH] <= word_data;
endmodule

// File: rtl/cache_block.sv
// cache_block: direct-mapped write-back write-allocate cache with line refill/eviction port
module cache_block #(
  parameter int LINE_WIDTH = cache_block_pkg::LINE_WIDTH,
  parameter int LINE_ADDR_START_INDEX = cache_block_pkg::LINE_ADDR_START_INDEX,
  parameter int NUM_LINES = cache_block_pkg::NUM_LINES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic                  enable,
  input  logic                  write_or_read,
  input  logic [31:0]           in_data,
  input  logic [LINE_WIDTH-1:0] from_memory_input_data,
  input  logic                  from_memory_write_enable,
  input  logic                  completed_write_to_memory,
  output logic [LINE_WIDTH-1:0] out_data,
  output logic                  ready,
  output logic                  cache_miss,
  output logic                  write_to_memory,
  output logic [31:0]           to_memory_address,
  output logic [LINE_WIDTH-1:0] to_memory_out_data
);
  import cache_block_pkg::*;
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - LINE_ADDR_START_INDEX - IW;
  localparam int WW = $clog2(LINE_WIDTH / INSTRUCTION_LENGTH);
  logic [IW-1:0] idx;
  logic [TW-1:0] tag, line_tag;
  logic [WW-1:0] word;
  logic [LINE_WIDTH-1:0] line_data;
  logic line_valid, line_dirty, hit, evict, unused_bits;
  assign idx = address[LINE_ADDR_START_INDEX +: IW];
  assign tag = address[31 -: TW];
  assign word = address[2 +: WW];
  assign unused_bits = ^{address[1:0], READ, NONE, ALWAYS_TRUE};
  assign hit = enable & line_valid & (line_tag == tag);
  assign ready = hit;
  assign cache_miss = enable & ~hit;
  assign evict = cache_miss & line_valid & line_dirty;
  assign write_to_memory = evict;
  assign out_data = hit ? line_data : '0;
  assign to_memory_out_data = evict ? line_data : '0;
  assign to_memory_address = evict ? {line_tag, idx, {LINE_ADDR_START_INDEX{1'b0}}}
                           : cache_miss ? {address[31:LINE_ADDR_START_INDEX], {LINE_ADDR_START_INDEX{1'b0}}} : '0;
  cache_block_line_store #(
    .LINE_WIDTH(LINE_WIDTH), .NUM_LINES(NUM_LINES), .IW(IW), .TW(TW), .WW(WW)
  ) u_store (
    .clock(clock),
    .reset(reset),
    .index(idx),
    .word(word),
    .word_data(in_data),
    .word_write(hit & (write_or_read == WRITE)),
    .fill(from_memory_write_enable & cache_miss & ~evict),
    .fill_tag(tag),
    .fill_data(from_memory_input_data),
    .clear_dirty(evict & completed_write_to_memory),
    .line_valid(line_valid),
    .line_dirty(line_dirty),
    .line_tag(line_tag),
    .line_data(line_data)
  );
endmodule

// File: tb/tb_cache_block.sv
// tb_cache_block: directed plus randomized checks of cache_block against a line-array model
module tb_cache_block;
  import cache_block_pkg::*;
  logic clock = 1'b0, reset = 1'b0;
  logic [31:0] address = '0, in_data = '0, to_memory_address;
  logic enable = 1'b0, write_or_read = READ;
  logic [127:0] from_memory_input_data = '0, out_data, to_memory_out_data;
  logic from_memory_write_enable = 1'b0, completed_write_to_memory = 1'b0;
  logic ready, cache_miss, write_to_memory;
  int checks = 0, errors = 0;
  bit m_valid [4], m_dirty [4];
  logic [31:0] m_tag [4];
  logic [127:0] m_data [4];
  localparam logic [127:0] L1 = 128'h4444DDDD_3333CCCC_2222BBBB_1111AAAA;
  localparam logic [127:0] L1W = 128'h4444DDDD_CAFEF00D_2222BBBB_1111AAAA;
  localparam logic [127:0] L2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] L3 = 128'h00000013_00A00093_00100113_DEADBEEF;

  cache_block dut (
    .clock(clock), .reset(reset), .address(address), .enable(enable),
    .write_or_read(write_or_read), .in_data(in_data),
    .from_memory_input_data(from_memory_input_data),
    .from_memory_write_enable(from_memory_write_enable),
    .completed_write_to_memory(completed_write_to_memory),
    .out_data(out_data), .ready(ready), .cache_miss(cache_miss),
    .write_to_memory(write_to_memory), .to_memory_address(to_memory_address),
    .to_memory_out_data(to_memory_out_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  task automatic model_eval(output int i, output bit hit, output bit miss, output bit ev);
    i = int'((address >> 4) & 32'd3);
    hit = enable && m_valid[i] && m_tag[i] == (address >> 6);
    miss = enable && !hit;
    ev = miss && m_valid[i] && m_dirty[i];
  endtask

  task automatic check_outputs(input string name);
    int i;
    bit hit, miss, ev;
    logic [31:0] ea;
    model_eval(i, hit, miss, ev);
    ea = ev ? (m_tag[i] << 6) | (i << 4) : miss ? address & 32'hFFFF_FFF0 : 32'h0;
    check({name, ".ready"}, 128'(ready), 128'(hit));
    check({name, ".miss"}, 128'(cache_miss), 128'(miss));
    check({name, ".wtm"}, 128'(write_to_memory), 128'(ev));
    check({name, ".maddr"}, 128'(to_memory_address), 128'(ea));
    check({name, ".out"}, out_data, hit ? m_data[i] : 128'h0);
    check({name, ".mdata"}, to_memory_out_data, ev ? m_data[i] : 128'h0);
  endtask

  task automatic tick();
    int i, w;
    bit hit, miss, ev;
    model_eval(i, hit, miss, ev);
    w = int'((address >> 2) & 32'd3);
    @(posedge clock);
    if (hit && write_or_read == WRITE) begin
      m_data[i][w*32 +: 32] = in_data;
      m_dirty[i] = 1;
    end
    if (ev && completed_write_to_memory) m_dirty[i] = 0;
    if (miss && !ev && from_memory_write_enable) begin
      m_valid[i] = 1;
      m_dirty[i] = 0;
      m_tag[i] = address >> 6;
      m_data[i] = from_memory_input_data;
    end
    #1;
    from_memory_write_enable = 1'b0;
    completed_write_to_memory = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input logic en, input logic wr, input logic [31:0] d);
    address = a;
    enable = en;
    write_or_read = wr;
    in_data = d;
    #1;
  endtask

  task automatic fill(input logic [127:0] line);
    from_memory_input_data = line;
    from_memory_write_enable = 1'b1;
    tick();
  endtask

  initial begin
    bit done, hit, miss, ev;
    int i;
    model_clear();
    access(32'h10, 1, READ, 0);
    check("rst.ready", 128'(ready), 128'd0);
    check("rst.miss", 128'(cache_miss), 128'd1);
    check("rst.wtm", 128'(write_to_memory), 128'd0);
    check("rst.maddr", 128'(to_memory_address), 128'h10);
    @(negedge clock);
    reset = 1'b1;
    #1 check_outputs("cold");
    fill(L1);
    check("fill.ready", 128'(ready), 128'd1);
    check("fill.out", out_data, L1);
    check_outputs("fill");
    access(32'h18, 1, WRITE, 32'hCAFEF00D);
    check_outputs("wr");
    tick();
    access(32'h10, 1, READ, 0);
    check("wr.out", out_data, L1W);
    check_outputs("wr.rd");
    access(32'h50, 1, READ, 0);
    check("ev.wtm", 128'(write_to_memory), 128'd1);
    check("ev.maddr", 128'(to_memory_address), 128'h10);
    check("ev.mdata", to_memory_out_data, L1W);
    fill(L2);
    check("ev.ignfill", 128'(write_to_memory), 128'd1);
    check_outputs("ev.ign");
    completed_write_to_memory = 1'b1;
    tick();
    check("ev.ack.wtm", 128'(write_to_memory), 128'd0);
    check("ev.ack.maddr", 128'(to_memory_address), 128'h50);
    fill(L2);
    check("ev.ready", 128'(ready), 128'd1);
    check("ev.out", out_data, L2);
    access(32'h0, 1, READ, 0);
    check_outputs("ic.miss");
    fill(L3);
    for (int pc = 0; pc < 16; pc += 4) begin
      access(32'(pc), 1, READ, 0);
      check("ic.ready", 128'(ready), 128'd1);
      check("ic.out", out_data, L3);
      tick();
    end
    access(32'h20, 0, READ, 0);
    from_memory_input_data = L2;
    from_memory_write_enable = 1'b1;
    #1 check_outputs("dis");
    check("dis.maddr", 128'(to_memory_address), 128'd0);
    tick();
    access(32'h20, 1, READ, 0);
    check("dis.later.miss", 128'(cache_miss), 128'd1);
    access(32'h4, 1, WRITE, 32'h1234_5678);
    tick();
    access(32'h40, 1, READ, 0);
    check("rstev.wtm", 128'(write_to_memory), 128'd1);
    reset = 1'b0;
    model_clear();
    #1;
    check("rstev.wtm0", 128'(write_to_memory), 128'd0);
    check("rstev.miss", 128'(cache_miss), 128'd1);
    access(32'h0, 1, READ, 0);
    check("rstev.old.miss", 128'(cache_miss), 128'd1);
    @(negedge clock);
    reset = 1'b1;
    #1 check_outputs("rstev.rel");
    tick();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        access($urandom, 0, 1'($urandom), $urandom);
        from_memory_input_data = {$urandom, $urandom, $urandom, $urandom};
        from_memory_write_enable = 1'($urandom);
        completed_write_to_memory = 1'($urandom);
        #1 check_outputs("rnd.idle");
        tick();
      end
      access(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3),
             1, 1'($urandom), $urandom);
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        check_outputs("rnd");
        model_eval(i, hit, miss, ev);
        done = hit;
        if (ev) completed_write_to_memory = 1'($urandom);
        from_memory_input_data = {$urandom, $urandom, $urandom, $urandom};
        from_memory_write_enable = 1'($urandom);
        tick();
      end
      if (!done) check("rnd.timeout", 128'd0, 128'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
